// File: rtl/i2c_slave_regctl.sv
// Register-file front end for an I2C slave: pointer byte then data bytes on writes, auto-increment on reads.
// Host port has single-cycle registered reads; an I2C write beats a same-cycle host write to the same register.
module i2c_slave_regctl #(
   parameter logic [6:0] DEV_ADDR = 7'h55,
   parameter int         NREGS    = 16,
   localparam int        PW       = $clog2(NREGS)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [6:0]    ADDR,
   input  logic          ARDY,
   input  logic          RW,
   input  logic [7:0]    ODATA,
   input  logic          DRDY,
   input  logic          BUSY,
   output logic [7:0]    IDATA,
   output logic          ACKA_RDY,
   output logic          ACKD_RDY,
   input  logic [PW-1:0] HADDR,
   input  logic          HWE,
   input  logic [7:0]    HWDATA,
   output logic [7:0]    HRDATA,
   output logic          WR_EVT,
   output logic [PW-1:0] WR_IDX
);

   typedef enum logic [2:0] {IDLE, ACHK, ACKA, XFER, ACKD, SKIP} state_t;

   state_t        state;
   logic [7:0]    regs [NREGS];
   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nxt;
   logic          first;
   logic          match;
   logic          rw_q;

   logic [1:0]    ardy_sync;
   logic [1:0]    drdy_sync;
   logic [1:0]    busy_sync;
   logic          ardy_d;
   logic          drdy_d;
   logic          busy_d;
   logic          ardy_arm;
   logic          drdy_arm;
   logic [1:0]    settle;
   logic          settled;
   logic          drdy_rise_q;

   logic          ardy_rise;
   logic          drdy_rise;
   logic          busy_fall;

   assign ptr_nxt   = ptr + 1'b1;
   assign settled   = (settle == 2'd2);
   assign ardy_rise = ardy_sync[1] & ~ardy_d & ardy_arm;
   assign drdy_rise = drdy_sync[1] & ~drdy_d & drdy_arm;
   assign busy_fall = ~busy_sync[1] & busy_d;

   // Edges only count once the synchronized level has been seen low after reset,
   // so a flag already high when reset releases is never mistaken for a new edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ardy_sync   <= '0;
         drdy_sync   <= '0;
         busy_sync   <= '0;
         ardy_d      <= 1'b0;
         drdy_d      <= 1'b0;
         busy_d      <= 1'b0;
         ardy_arm    <= 1'b0;
         drdy_arm    <= 1'b0;
         settle      <= '0;
         drdy_rise_q <= 1'b0;
      end else begin
         ardy_sync   <= {ardy_sync[0], ARDY};
         drdy_sync   <= {drdy_sync[0], DRDY};
         busy_sync   <= {busy_sync[0], BUSY};
         ardy_d      <= ardy_sync[1];
         drdy_d      <= drdy_sync[1];
         busy_d      <= busy_sync[1];
         ardy_arm    <= ardy_arm | (settled & ~ardy_sync[1]);
         drdy_arm    <= drdy_arm | (settled & ~drdy_sync[1]);
         drdy_rise_q <= drdy_rise;
         if (!settled)
            settle <= settle + 2'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         regs     <= '{default: '0};
         ptr      <= '0;
         IDATA    <= '0;
         ACKA_RDY <= 1'b0;
         ACKD_RDY <= 1'b0;
         WR_EVT   <= 1'b0;
         WR_IDX   <= '0;
         HRDATA   <= '0;
         first    <= 1'b0;
         match    <= 1'b0;
         rw_q     <= 1'b0;
      end else begin
         WR_EVT <= 1'b0;
         HRDATA <= regs[HADDR];
         // Host write first so a same-cycle I2C write to the same index overrides it.
         if (HWE)
            regs[HADDR] <= HWDATA;

         if (busy_fall) begin
            state    <= IDLE;
            ACKA_RDY <= 1'b0;
            ACKD_RDY <= 1'b0;
            match    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  ACKA_RDY <= 1'b0;
                  ACKD_RDY <= 1'b0;
                  if (ardy_rise)
                     state <= ACHK;
               end
               ACHK: begin
                  match <= (ADDR == DEV_ADDR);
                  if (ADDR == DEV_ADDR) begin
                     first <= ~RW;
                     rw_q  <= RW;
                     if (RW)
                        IDATA <= regs[ptr];
                  end
                  ACKA_RDY <= 1'b1;
                  state    <= ACKA;
               end
               ACKA: begin
                  if (!ardy_sync[1]) begin
                     ACKA_RDY <= 1'b0;
                     state    <= match ? XFER : SKIP;
                  end
               end
               XFER: begin
                  // A new ARDY edge here is a repeated start.
                  if (ardy_rise) begin
                     state <= ACHK;
                  end else if (drdy_rise_q) begin
                     if (rw_q) begin
                        ptr   <= ptr_nxt;
                        IDATA <= regs[ptr_nxt];
                     end else if (first) begin
                        ptr   <= ODATA[PW-1:0];
                        first <= 1'b0;
                     end else begin
                        regs[ptr] <= ODATA;
                        WR_EVT    <= 1'b1;
                        WR_IDX    <= ptr;
                        ptr       <= ptr_nxt;
                     end
                     ACKD_RDY <= 1'b1;
                     state    <= ACKD;
                  end
               end
               ACKD: begin
                  if (!drdy_sync[1]) begin
                     ACKD_RDY <= 1'b0;
                     state    <= XFER;
                  end
               end
               SKIP: begin
                  ACKD_RDY <= drdy_sync[1];
                  if (ardy_rise)
                     state <= ACHK;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_regctl.sv
// Directed bench for i2c_slave_regctl: drives the i2c_slave-side handshakes and the host port.
module tb_i2c_slave_regctl;

   logic       CLK = 1'b0;
   logic       RST;
   logic [6:0] ADDR;
   logic       ARDY;
   logic       RW;
   logic [7:0] ODATA;
   logic       DRDY;
   logic       BUSY;
   logic [7:0] IDATA;
   logic       ACKA_RDY;
   logic       ACKD_RDY;
   logic [3:0] HADDR;
   logic       HWE;
   logic [7:0] HWDATA;
   logic [7:0] HRDATA;
   logic       WR_EVT;
   logic [3:0] WR_IDX;

   int total = 0;
   int bad   = 0;

   logic [3:0] wr_q [$];
   logic [7:0] rd_q [$];

   i2c_slave_regctl #(.DEV_ADDR(7'h55), .NREGS(16)) dut (
      .CLK(CLK), .RST(RST), .ADDR(ADDR), .ARDY(ARDY), .RW(RW), .ODATA(ODATA),
      .DRDY(DRDY), .BUSY(BUSY), .IDATA(IDATA), .ACKA_RDY(ACKA_RDY), .ACKD_RDY(ACKD_RDY),
      .HADDR(HADDR), .HWE(HWE), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .WR_EVT(WR_EVT), .WR_IDX(WR_IDX)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Each WR_EVT pulse consumes one expected index.
   always @(negedge CLK) begin
      if (WR_EVT === 1'b1) begin
         total++;
         assert (wr_q.size() != 0) else begin
            bad++;
            $error("FAIL wr_evt_unexpected: got idx %0d expected no event", WR_IDX);
         end
         if (wr_q.size() != 0)
            check("wr_idx", {4'd0, WR_IDX}, {4'd0, wr_q.pop_front()});
      end
   end

   task automatic wait_acka(input logic lvl, input string tag);
      int n = 0;
      while (ACKA_RDY !== lvl && n < 64) begin
         @(negedge CLK);
         n++;
      end
      check(tag, {7'd0, ACKA_RDY}, {7'd0, lvl});
   endtask

   task automatic wait_ackd(input logic lvl, input string tag);
      int n = 0;
      while (ACKD_RDY !== lvl && n < 64) begin
         @(negedge CLK);
         n++;
      end
      check(tag, {7'd0, ACKD_RDY}, {7'd0, lvl});
   endtask

   task automatic start_addr(input logic [6:0] a, input logic rw);
      @(negedge CLK);
      BUSY = 1'b1;
      ADDR = a;
      RW   = rw;
      ARDY = 1'b1;
      wait_acka(1'b1, "acka_hi");
      ARDY = 1'b0;
      wait_acka(1'b0, "acka_lo");
   endtask

   task automatic wr_byte(input logic [7:0] d, input bit push, input logic [3:0] idx);
      @(negedge CLK);
      ODATA = d;
      if (push)
         wr_q.push_back(idx);
      DRDY = 1'b1;
      wait_ackd(1'b1, "ackd_hi");
      DRDY = 1'b0;
      wait_ackd(1'b0, "ackd_lo");
   endtask

   // Host strobe lands on the exact cycle the DUT commits the I2C byte.
   task automatic wr_byte_host(input logic [7:0] d, input logic [3:0] idx,
                               input logic [3:0] ha, input logic [7:0] hd);
      @(negedge CLK);
      ODATA = d;
      wr_q.push_back(idx);
      DRDY = 1'b1;
      repeat (3) @(negedge CLK);
      HADDR  = ha;
      HWDATA = hd;
      HWE    = 1'b1;
      @(negedge CLK);
      HWE = 1'b0;
      check("collide_evt", {7'd0, WR_EVT}, 8'd1);
      wait_ackd(1'b1, "ackd_hi");
      DRDY = 1'b0;
      wait_ackd(1'b0, "ackd_lo");
   endtask

   task automatic rd_byte(input logic [7:0] exp);
      rd_q.push_back(exp);
      @(negedge CLK);
      check("idata", IDATA, rd_q.pop_front());
      DRDY = 1'b1;
      wait_ackd(1'b1, "ackd_hi");
      DRDY = 1'b0;
      wait_ackd(1'b0, "ackd_lo");
   endtask

   task automatic stop_bus();
      @(negedge CLK);
      BUSY = 1'b0;
      repeat (6) @(negedge CLK);
   endtask

   task automatic host_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge CLK);
      HADDR  = a;
      HWDATA = d;
      HWE    = 1'b1;
      @(negedge CLK);
      HWE = 1'b0;
   endtask

   task automatic host_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
      @(negedge CLK);
      HADDR = a;
      @(negedge CLK);
      check(tag, HRDATA, exp);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_idata"}, IDATA, 8'h00);
      check({tag, "_acka"}, {7'd0, ACKA_RDY}, 8'h00);
      check({tag, "_ackd"}, {7'd0, ACKD_RDY}, 8'h00);
      check({tag, "_wrevt"}, {7'd0, WR_EVT}, 8'h00);
      check({tag, "_wridx"}, {4'd0, WR_IDX}, 8'h00);
      check({tag, "_hrdata"}, HRDATA, 8'h00);
   endtask

   initial begin
      RST = 1'b1; ADDR = '0; ARDY = 1'b0; RW = 1'b0; ODATA = '0; DRDY = 1'b0;
      BUSY = 1'b0; HADDR = 4'd3; HWE = 1'b0; HWDATA = '0;
      repeat (3) @(negedge CLK);
      check_reset_outs("reset");
      RST = 1'b0;
      repeat (4) @(negedge CLK);
      host_write(4'd5, 8'h5A);

      // Pointer 3, then two data bytes.
      start_addr(7'h55, 1'b0);
      wr_byte(8'h03, 1'b0, 4'd0);
      wr_byte(8'hDE, 1'b1, 4'd3);
      wr_byte(8'hAD, 1'b1, 4'd4);
      stop_bus();
      host_read(4'd3, 8'hDE, "wr_reg3");
      host_read(4'd4, 8'hAD, "wr_reg4");
      check("wr_idx_held", {4'd0, WR_IDX}, 8'd4);

      // Pointer left at 5; host rewrites regs[5] after IDATA is already loaded.
      start_addr(7'h55, 1'b1);
      host_write(4'd5, 8'hA5);
      rd_byte(8'h5A);
      stop_bus();

      // Pointer write, repeated start, two reads.
      start_addr(7'h55, 1'b0);
      wr_byte(8'h03, 1'b0, 4'd0);
      start_addr(7'h55, 1'b1);
      rd_byte(8'hDE);
      rd_byte(8'hAD);
      stop_bus();
      start_addr(7'h55, 1'b1);
      rd_byte(8'hA5);
      stop_bus();

      // Foreign address: handshakes still complete, nothing written.
      start_addr(7'h22, 1'b0);
      wr_byte(8'h03, 1'b0, 4'd0);
      wr_byte(8'h11, 1'b0, 4'd0);
      wr_byte(8'h22, 1'b0, 4'd0);
      stop_bus();
      host_read(4'd3, 8'hDE, "skip_reg3");
      host_read(4'd4, 8'hAD, "skip_reg4");
      check("skip_wridx", {4'd0, WR_IDX}, 8'd4);

      // Pointer wrap.
      start_addr(7'h55, 1'b0);
      wr_byte(8'h0F, 1'b0, 4'd0);
      wr_byte(8'h11, 1'b1, 4'd15);
      wr_byte(8'h22, 1'b1, 4'd0);
      stop_bus();
      host_read(4'd15, 8'h11, "wrap_reg15");
      host_read(4'd0, 8'h22, "wrap_reg0");
      host_write(4'd1, 8'h3C);
      start_addr(7'h55, 1'b1);
      rd_byte(8'h3C);
      stop_bus();

      // Host and I2C writes in the same cycle.
      start_addr(7'h55, 1'b0);
      wr_byte(8'h03, 1'b0, 4'd0);
      wr_byte_host(8'h99, 4'd3, 4'd3, 8'h77);
      wr_byte_host(8'h55, 4'd4, 4'd7, 8'h77);
      stop_bus();
      host_read(4'd3, 8'h99, "collide_same");
      host_read(4'd7, 8'h77, "collide_diff");
      host_read(4'd4, 8'h55, "collide_reg4");

      // Reset while the DUT is holding ACKD_RDY.
      start_addr(7'h55, 1'b0);
      wr_byte(8'h02, 1'b0, 4'd0);
      @(negedge CLK);
      ODATA = 8'h66;
      wr_q.push_back(4'd2);
      DRDY = 1'b1;
      wait_ackd(1'b1, "pre_rst_ackd");
      HADDR = 4'd3;
      RST = 1'b1;
      @(negedge CLK);
      check_reset_outs("midrst");
      RST = 1'b0;
      repeat (6) @(negedge CLK);
      check("post_rst_ackd", {7'd0, ACKD_RDY}, 8'h00);
      DRDY = 1'b0;
      BUSY = 1'b0;
      repeat (6) @(negedge CLK);
      host_read(4'd3, 8'h00, "post_rst_reg3");
      start_addr(7'h55, 1'b0);
      wr_byte(8'h02, 1'b0, 4'd0);
      wr_byte(8'h42, 1'b1, 4'd2);
      stop_bus();
      host_read(4'd2, 8'h42, "post_rst_reg2");

      total++;
      assert (wr_q.size() == 0) else begin
         bad++;
         $error("FAIL wr_evt_missing: got %0d pending expected 0", wr_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_slave_regctl.md
I2C_SLAVE_REGCTL -- requirements
Module: i2c_slave_regctl

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h55: 7-bit device address answered on the bus.
REQ-002 SHALL have parameter NREGS, default 16: register count, power of two; PW = log2(NREGS) is the pointer width.
REQ-003 CLK  in  1  single system clock; all logic rising-edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 ADDR  in  7  received address from i2c_slave, valid while ARDY high.
REQ-006 ARDY  in  1  address-received flag from i2c_slave.
REQ-007 RW  in  1  transfer direction from i2c_slave, 1 = read; valid while ARDY high.
REQ-008 ODATA  in  8  byte written by the master, valid while DRDY high.
REQ-009 DRDY  in  1  byte-done flag from i2c_slave.
REQ-010 BUSY  in  1  i2c_slave transaction-active flag.
REQ-011 IDATA  out  8  byte for i2c_slave to transmit on reads.
REQ-012 ACKA_RDY  out  1  releases the address-ACK stall in i2c_slave.
REQ-013 ACKD_RDY  out  1  releases the data-ACK stall in i2c_slave.
REQ-014 HADDR  in  PW  host register address.
REQ-015 HWE  in  1  host write strobe.
REQ-016 HWDATA  in  8  host write data.
REQ-017 HRDATA  out  8  host read data, regs[HADDR] registered, 1-cycle latency.
REQ-018 WR_EVT  out  1  one-cycle pulse per I2C register write.
REQ-019 WR_IDX  out  PW  index of the last I2C-written register, valid with WR_EVT and held afterwards.

Function
REQ-020 ARDY, DRDY and BUSY SHALL each pass through a 2-flop synchronizer; edge detection SHALL use the synchronized copies; ADDR, RW and ODATA SHALL be sampled only in the cycle after a synchronized rising edge.
REQ-021 FSM states SHALL be IDLE, ACHK, ACKA, XFER, ACKD and SKIP.
REQ-022 IDLE: ACKA_RDY=0, ACKD_RDY=0; synchronized ARDY rising edge -> ACHK.
REQ-023 ACHK, one cycle: on ADDR==DEV_ADDR set MATCH, set FIRST=~RW, and if RW=1 load IDATA<=regs[ptr]; on any ADDR set ACKA_RDY=1 and go to ACKA.
REQ-024 ACKA: hold ACKA_RDY=1 until synchronized ARDY is low, then ACKA_RDY=0 and go to XFER if MATCH, else SKIP.
REQ-025 XFER write, synchronized DRDY rising edge with FIRST=1: ptr<=ODATA[PW-1:0], FIRST<=0, no register write.
REQ-026 XFER write, synchronized DRDY rising edge with FIRST=0: regs[ptr]<=ODATA, WR_EVT=1, WR_IDX<=ptr, ptr<=ptr+1.
REQ-027 XFER read, synchronized DRDY rising edge: ptr<=ptr+1, IDATA<=regs[ptr+1].
REQ-028 XFER, after any DRDY rising edge: ACKD_RDY=1 and go to ACKD.
REQ-029 ACKD: hold ACKD_RDY=1 until synchronized DRDY is low, then ACKD_RDY=0 and return to XFER.
REQ-030 SKIP: ACKD_RDY SHALL pulse high while synchronized DRDY is high so the bus never hangs; no register or pointer change.
REQ-031 A synchronized BUSY falling edge in any state SHALL return the FSM to IDLE, clear ACKA_RDY, ACKD_RDY and MATCH, and retain ptr and regs.
REQ-032 ptr SHALL wrap modulo NREGS: NREGS-1 -> 0.
REQ-033 Host write and I2C write to the same register in the same cycle: the I2C write SHALL win; writes to different registers SHALL both take effect.
REQ-034 A host write to regs[ptr] during a read SHALL NOT alter IDATA already loaded.

Reset
REQ-035 While RST=1: state=IDLE, all regs=0, ptr=0, IDATA=0, ACKA_RDY=0, ACKD_RDY=0, WR_EVT=0, WR_IDX=0, HRDATA=0, FIRST=0, MATCH=0, synchronizers=0.
REQ-036 RST asserted mid-transaction SHALL take effect in the next cycle; after release the FSM SHALL ignore the current ARDY/DRDY levels until a fresh rising edge.

Verification
REQ-037 Write: start, 0xAA (0x55,W), 0x03, 0xDE, 0xAD, stop -> regs[3]=0xDE, regs[4]=0xAD, two WR_EVT pulses with WR_IDX 3 then 4, ptr=5.
REQ-038 Read: write pointer 0x03, repeated start, 0xAB, read 2 bytes ACK/NACK -> master receives 0xDE then 0xAD; ptr=5.
REQ-039 Address 0x22 write, 3 data bytes -> no register change and no WR_EVT; ACKA_RDY and ACKD_RDY still handshake each byte.
REQ-040 Wrap: pointer 0x0F, write 0x11, 0x22 -> regs[15]=0x11, regs[0]=0x22, ptr=1.
REQ-041 Host HWE to index 3 with data 0x77 in the same cycle as an I2C write of 0x99 to regs[3] -> regs[3]=0x99; host write to index 7 in that cycle -> regs[7]=0x77.
REQ-042 RST pulse during ACKD -> all outputs at reset values next cycle; the following transaction completes normally.
